// File: rtl/ads1675_decim_avg.sv
// Boxcar decimator for the ADS1675 capture path: averages 2^LOG2_N samples
// into one and buffers results in a small FIFO with overflow accounting.
module ads1675_decim_avg #(
    parameter int DW         = 24,
    parameter int LOG2_N     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          sclk,
    input  logic          areset_n,
    input  logic          en,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          ovf,
    output logic [15:0]   ovf_cnt
);

    localparam int AW = DW + LOG2_N;
    localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int N  = 1 << LOG2_N;
    localparam int PW = $clog2(FIFO_DEPTH);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] in_ext;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] sum_shr;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 group_done;
    logic [DW-1:0]        result;

    assign accept     = en & in_valid;
    assign in_ext     = AW'($signed(in_data));
    assign sum        = acc + in_ext;
    // Floor-rounded mean; the mean of in-range samples always fits in DW bits.
    assign sum_shr    = sum >>> LOG2_N;
    assign result     = sum_shr[DW-1:0];
    assign group_done = accept && (cnt == CW'(N - 1));

    always_ff @(posedge sclk) begin
        if (!areset_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (group_done) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Stream handshake: a result transfers on any rising edge with m_valid and
    // m_ready both high; m_valid never drops and m_data never changes until then.
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          drop;

    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign m_valid = (count != '0);
    assign m_data  = mem[rd_ptr];
    assign pop     = m_valid & m_ready;
    assign wr_en   = group_done & (~full | pop);
    assign drop    = group_done & full & ~pop;

    always_ff @(posedge sclk) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (!areset_n) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_cnt != 16'hFFFF) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ads1675_decim_avg.sv
// Randomized and directed bench for ads1675_decim_avg with a queue-based
// reference model of group means, FIFO occupancy and drop counting.
module tb_ads1675_decim_avg;

    localparam int DW    = 24;
    localparam int N     = 8;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic          sclk     = 1'b0;
    logic          areset_n = 1'b0;
    logic          en       = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          m_ready  = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          ovf;
    logic [15:0]   ovf_cnt;

    logic          in_valid0 = 1'b0;
    logic [DW-1:0] in_data0  = '0;
    logic [DW-1:0] m_data0;
    logic          m_valid0;
    logic          ovf0;
    logic [15:0]   ovf_cnt0;

    always #5 sclk = ~sclk;

    ads1675_decim_avg #(.DW(DW), .LOG2_N(3), .FIFO_DEPTH(DEPTH)) dut (
        .sclk(sclk), .areset_n(areset_n), .en(en), .in_data(in_data),
        .in_valid(in_valid), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .ovf(ovf), .ovf_cnt(ovf_cnt)
    );

    ads1675_decim_avg #(.DW(DW), .LOG2_N(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .sclk(sclk), .areset_n(areset_n), .en(1'b1), .in_data(in_data0),
        .in_valid(in_valid0), .m_data(m_data0), .m_valid(m_valid0),
        .m_ready(1'b1), .ovf(ovf0), .ovf_cnt(ovf_cnt0)
    );

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            passes = 0;
    int            pops   = 0;
    logic [DW-1:0] exp_q[$];
    longint        grp[$];
    bit            push_pend = 1'b0;
    logic [DW-1:0] pend_val  = '0;
    int            exp_ovf   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge sclk) begin
        if (!areset_n) begin
            exp_q.delete();
            push_pend = 1'b0;
            exp_ovf   = 0;
        end else begin
            check("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
            check("ovf_cnt", 64'(ovf_cnt), 64'(exp_ovf));
            check("ovf", 64'(ovf), 64'(exp_ovf != 0));
            if (m_ready && exp_q.size() != 0) begin
                check("m_data", 64'(m_data), 64'(exp_q.pop_front()));
                pops++;
            end
            if (push_pend) begin
                push_pend = 1'b0;
                if (exp_q.size() < DEPTH) exp_q.push_back(pend_val);
                else if (exp_ovf < 65535) exp_ovf++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input longint v, input int gap);
        longint s;
        longint q;
        in_data  = v[DW-1:0];
        in_valid = 1'b1;
        if (en) begin
            grp.push_back(v);
            if (grp.size() == N) begin
                s = 0;
                foreach (grp[i]) s += grp[i];
                q = s / N;
                if ((s % N) != 0 && s < 0) q = q - 1;
                pend_val  = q[DW-1:0];
                push_pend = 1'b1;
                grp.delete();
            end
        end
        @(posedge sclk); #1;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge sclk); #1; end
    endtask

    task automatic send_n(input int n, input longint v, input int gap);
        for (int i = 0; i < n; i++) send(v, gap);
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        grp.delete();
        @(posedge sclk); #1;
        areset_n = 1'b1;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge sclk); #1;
            if (exp_q.size() == 0 && !push_pend) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) begin @(posedge sclk); #1; end
    endtask

    task automatic echo0(input logic [DW-1:0] v);
        in_data0  = v;
        in_valid0 = 1'b1;
        @(posedge sclk); #1;
        in_valid0 = 1'b0;
        @(negedge sclk);
        check("echo_valid", 64'(m_valid0), 64'd1);
        check("echo_data", 64'(m_data0), 64'(v));
        @(posedge sclk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            pops_before;
        logic [DW-1:0] r;
        longint        v;

        repeat (2) @(posedge sclk);
        #1;
        areset_n = 1'b1;
        @(negedge sclk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        @(posedge sclk); #1;

        // basic means, floor rounding, full scale
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(i, 2);
        send_n(8, -1, 1);
        send_n(7, 0, 0); send(-3, 0);
        send_n(7, 0, 0); send(7, 0);
        send_n(8, 64'sh7FFFFF, 0);
        send_n(8, -64'sh800000, 0);
        wait_drain();

        // overflow with five groups while stalled
        m_ready = 1'b0;
        for (int g = 1; g <= 5; g++) send_n(8, g * 10, 0);
        repeat (2) begin @(posedge sclk); #1; end
        @(negedge sclk);
        check("ovf_after5", 64'(ovf), 64'd1);
        check("ovf_cnt_after5", 64'(ovf_cnt), 64'd1);
        @(posedge sclk); #1;
        m_ready = 1'b1;
        wait_drain();
        @(negedge sclk);
        check("drained_m_valid", 64'(m_valid), 64'd0);
        @(posedge sclk); #1;

        // full FIFO with push and pop on the same edge
        m_ready = 1'b0;
        for (int g = 5; g <= 8; g++) send_n(8, g, 0);
        send_n(7, 9, 0);
        m_ready = 1'b1;
        send(9, 0);
        m_ready = 1'b0;
        repeat (3) begin @(posedge sclk); #1; end
        @(negedge sclk);
        check("full_pop_ovf_cnt", 64'(ovf_cnt), 64'd1);
        @(posedge sclk); #1;
        pops_before = pops;
        m_ready = 1'b1;
        wait_drain();
        check("full_pop_remaining", 64'(pops - pops_before), 64'd4);

        // mid-group reset, then en hold
        send_n(3, 100, 1);
        do_reset();
        send_n(8, 16, 1);
        wait_drain();
        send_n(4, 8, 1);
        en = 1'b0;
        send_n(5, 999, 1);
        en = 1'b1;
        send_n(4, 8, 1);
        wait_drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r       = DW'($urandom);
            v       = longint'(r);
            if (r[DW-1]) v = v - (64'sd1 <<< DW);
            en      = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            send(v, $urandom_range(0, 3));
        end
        en      = 1'b1;
        m_ready = 1'b1;
        wait_drain();

        // pass-through instance
        echo0(24'h000001);
        echo0(24'h7FFFFF);
        echo0(24'h800000);
        for (int i = 0; i < 5; i++) echo0(DW'($urandom));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
